// File: rtl/n64adv_ctrl_sniffer_mc.sv
// ---------------------------------------------------------------------------
// n64adv_ctrl_sniffer_mc
//   Passive sniffer for NUM_CH N64 joybus controller lines in the VCLK domain.
//   Each line is synchronised, sampled on a shared prescaler tick and decoded
//   by a per-channel FSM that follows the poll command (0x01) and captures the
//   32-bit controller response. A watched channel drives a debounced
//   in-game-reset (IGR) trigger.
//
// Ports
//   VCLK              clock
//   nRST              synchronous reset, active high
//   i_ctrl            raw joybus lines, asynchronous to VCLK
//   i_vsync_negedge   one-cycle frame strobe
//   i_use_igr         IGR enable
//   o_ctrl_data       latest response per channel, channel c at [32c+31:32c]
//   o_ctrl_valid      one-cycle pulse when o_ctrl_data of a channel updates
//   o_ctrl_new        sticky "new data this frame", cleared by vsync
//   o_ctrl_err        one-cycle pulse when a response is aborted by timeout
//   o_igr_trigger     one-cycle reset request
//
// Decoder states
//   state   | meaning
//   IDLE    | waiting for a falling edge after a long high period
//   CMD     | decoding the 8 command bits, MSB first
//   RESP    | skipping the host stop bit, then 32 response bits, LSB first
// ---------------------------------------------------------------------------
module n64adv_ctrl_sniffer_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          CLK_DIV   = 12,
  parameter int          WAIT_W    = 6,
  parameter int          IGR_CH    = 0,
  parameter logic [15:0] IGR_COMBO = 16'h3030,
  parameter int          IGR_HOLD  = 8
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic [NUM_CH-1:0]      i_ctrl,
  input  logic                   i_vsync_negedge,
  input  logic                   i_use_igr,
  output logic [32*NUM_CH-1:0]   o_ctrl_data,
  output logic [NUM_CH-1:0]      o_ctrl_valid,
  output logic [NUM_CH-1:0]      o_ctrl_new,
  output logic [NUM_CH-1:0]      o_ctrl_err,
  output logic                   o_igr_trigger
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // shared sample tick
  logic [PRE_W-1:0]   r_presc;
  logic               w_tick;

  // per-channel sampling and decode
  logic [NUM_CH-1:0]  r_sync1;
  logic [NUM_CH-1:0]  r_sync2;
  logic [2:0]         r_hist     [NUM_CH];
  logic [WAIT_W-1:0]  r_wait_cnt [NUM_CH];
  logic [WAIT_W-1:0]  r_low_cnt  [NUM_CH];
  state_t             r_state    [NUM_CH];
  logic [5:0]         r_bit_cnt  [NUM_CH];
  logic [6:0]         r_cmd_sr   [NUM_CH];
  logic [30:0]        r_data_sr  [NUM_CH];
  logic [31:0]        r_data     [NUM_CH];
  logic [NUM_CH-1:0]  r_valid;
  logic [NUM_CH-1:0]  r_new;
  logic [NUM_CH-1:0]  r_err;

  logic [NUM_CH-1:0]  w_neg;
  logic [NUM_CH-1:0]  w_pos;
  logic [NUM_CH-1:0]  w_bit;
  logic [NUM_CH-1:0]  w_wait_max;

  // IGR
  logic [7:0]         r_igr_cnt;
  logic               r_igr_armed;
  logic               r_igr_trig;
  logic               w_combo;

  assign w_tick = (r_presc == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge VCLK) begin
    if (nRST) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Edges are taken from the two older history bits, so they are stable for
  // a whole tick period; all users below act on the tick only.
  always_comb begin
    w_neg      = '0;
    w_pos      = '0;
    w_bit      = '0;
    w_wait_max = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_neg[c]      = r_hist[c][2] & ~r_hist[c][1];
      w_pos[c]      = ~r_hist[c][2] & r_hist[c][1];
      // a '1' bit is short low / long high, a '0' bit the opposite
      w_bit[c]      = (r_low_cnt[c] < r_wait_cnt[c]);
      w_wait_max[c] = (r_wait_cnt[c] == {WAIT_W{1'b1}});
    end
  end

  always_ff @(posedge VCLK) begin
    if (nRST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_valid <= '0;
      r_new   <= '0;
      r_err   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_hist[c]     <= 3'b111;
        r_wait_cnt[c] <= '0;
        r_low_cnt[c]  <= '0;
        r_state[c]    <= ST_IDLE;
        r_bit_cnt[c]  <= '0;
        r_cmd_sr[c]   <= '0;
        r_data_sr[c]  <= '0;
        r_data[c]     <= '0;
      end
    end else begin
      r_sync1 <= i_ctrl;
      r_sync2 <= r_sync1;
      r_valid <= '0;
      r_err   <= '0;
      // r_valid is the set term, so a vsync in the same cycle as the
      // ctrl_valid pulse leaves ctrl_new set
      r_new   <= (r_new & ~{NUM_CH{i_vsync_negedge}}) | r_valid;

      for (int c = 0; c < NUM_CH; c++) begin
        if (w_tick) begin
          r_hist[c] <= {r_hist[c][1:0], r_sync2[c]};

          if (w_neg[c] || w_pos[c]) begin
            r_wait_cnt[c] <= '0;
          end else if (!w_wait_max[c]) begin
            r_wait_cnt[c] <= r_wait_cnt[c] + 1'b1;
          end

          if (w_pos[c]) begin
            r_low_cnt[c] <= r_wait_cnt[c];
          end

          case (r_state[c])
            ST_IDLE: begin
              if (w_neg[c] && w_wait_max[c]) begin
                r_state[c]   <= ST_CMD;
                r_bit_cnt[c] <= '0;
              end
            end

            ST_CMD: begin
              if (w_wait_max[c]) begin
                r_state[c] <= ST_IDLE;
              end else if (w_neg[c]) begin
                r_cmd_sr[c]  <= {r_cmd_sr[c][5:0], w_bit[c]};
                r_bit_cnt[c] <= r_bit_cnt[c] + 1'b1;
                if (r_bit_cnt[c] == 6'd7) begin
                  r_bit_cnt[c] <= '0;
                  if ({r_cmd_sr[c], w_bit[c]} == 8'h01) begin
                    r_state[c] <= ST_RESP;
                  end else begin
                    r_state[c] <= ST_IDLE;
                  end
                end
              end
            end

            ST_RESP: begin
              if (w_wait_max[c]) begin
                r_state[c] <= ST_IDLE;
                r_err[c]   <= 1'b1;
              end else if (w_neg[c]) begin
                r_bit_cnt[c] <= r_bit_cnt[c] + 1'b1;
                // the first falling edge only closes the host stop bit
                if (r_bit_cnt[c] != 6'd0) begin
                  r_data_sr[c] <= {w_bit[c], r_data_sr[c][30:1]};
                end
                if (r_bit_cnt[c] == 6'd32) begin
                  r_data[c]  <= {w_bit[c], r_data_sr[c]};
                  r_valid[c] <= 1'b1;
                  r_state[c] <= ST_IDLE;
                end
              end
            end

            default: r_state[c] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign w_combo = (r_data[IGR_CH][15:0] == IGR_COMBO);

  // The combo must be released once before it can fire again.
  always_ff @(posedge VCLK) begin
    if (nRST) begin
      r_igr_cnt   <= '0;
      r_igr_armed <= 1'b1;
      r_igr_trig  <= 1'b0;
    end else begin
      r_igr_trig <= 1'b0;
      if (!i_use_igr) begin
        r_igr_cnt <= '0;
      end
      if (i_vsync_negedge) begin
        if (!w_combo) begin
          r_igr_armed <= 1'b1;
        end
        if (i_use_igr) begin
          if (w_combo && r_igr_armed) begin
            if (r_igr_cnt == 8'(IGR_HOLD - 1)) begin
              r_igr_trig  <= 1'b1;
              r_igr_cnt   <= '0;
              r_igr_armed <= 1'b0;
            end else begin
              r_igr_cnt <= r_igr_cnt + 1'b1;
            end
          end else begin
            r_igr_cnt <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign o_ctrl_data[32*g +: 32] = r_data[g];
  end

  assign o_ctrl_valid  = r_valid;
  assign o_ctrl_new    = r_new;
  assign o_ctrl_err    = r_err;
  assign o_igr_trigger = r_igr_trig;

endmodule
